// File: rtl/multi_valid_array.sv
// Per-set way state array (valid or valid+dirty bits) with one read port,
// one pipelined masked write port and a sequential whole-array flush engine.
module multi_valid_array #(
  parameter int unsigned S_INDEX = 4,
  parameter int unsigned WAYS    = 4,
  parameter int unsigned WIDTH   = 1
) (
  input  logic                     clk0,
  input  logic                     rst0,
  input  logic                     csb0,
  input  logic [S_INDEX-1:0]       addr0,
  output logic [WAYS*WIDTH-1:0]    dout0,
  input  logic                     csb1,
  input  logic [S_INDEX-1:0]       addr1,
  input  logic [WAYS-1:0]          wmask1,
  input  logic [WAYS*WIDTH-1:0]    din1,
  input  logic                     flush_req,
  output logic                     flush_busy,
  output logic                     flush_done
);

  localparam int unsigned NumSets = 2 ** S_INDEX;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StFlush = 1'b1;

  logic [WAYS*WIDTH-1:0] mem_q [NumSets];
  logic [S_INDEX-1:0]    raddr_q;

  logic                  wr_pend_q;
  logic [S_INDEX-1:0]    waddr_q;
  logic [WAYS-1:0]       wmask_q;
  logic [WAYS*WIDTH-1:0] wdata_q;

  logic [0:0]            state_q, state_d;
  logic [S_INDEX-1:0]    cnt_q;
  logic                  done_q;

  logic flush_start;
  logic flush_last;
  logic wr_accept;

  always_comb begin
    flush_start = (state_q == StIdle) && flush_req;
    flush_last  = (state_q == StFlush) && (cnt_q == S_INDEX'(NumSets - 1));
    // Writes are dropped while flushing and on the edge that starts a flush.
    wr_accept   = !csb1 && (state_q == StIdle) && !flush_req;
    state_d     = state_q;
    if (flush_start) begin
      state_d = StFlush;
    end else if (flush_last) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      for (int s = 0; s < NumSets; s++) begin
        mem_q[s] <= '0;
      end
      raddr_q   <= '0;
      wr_pend_q <= 1'b0;
      waddr_q   <= '0;
      wmask_q   <= '0;
      wdata_q   <= '0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      if (!csb0) begin
        raddr_q <= addr0;
      end

      wr_pend_q <= wr_accept;
      if (wr_accept) begin
        waddr_q <= addr1;
        wmask_q <= wmask1;
        wdata_q <= din1;
      end

      // A pending write can only exist while idle, so it never races a clear.
      if (wr_pend_q) begin
        for (int w = 0; w < WAYS; w++) begin
          if (wmask_q[w]) begin
            mem_q[waddr_q][w*WIDTH +: WIDTH] <= wdata_q[w*WIDTH +: WIDTH];
          end
        end
      end

      if (state_q == StFlush) begin
        mem_q[cnt_q] <= '0;
        cnt_q        <= cnt_q + 1'b1;
      end

      state_q <= state_d;
      done_q  <= flush_last;
    end
  end

  assign dout0      = mem_q[raddr_q];
  assign flush_busy = (state_q == StFlush);
  assign flush_done = done_q;

endmodule
